// File: rtl/conv2d_stream_k.sv
// conv2d_stream_k: streaming KxK "valid" convolution of a raster pixel stream.
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_data pixel input;
// kernel_wr/kernel_addr/kernel_data write the shadow coefficient bank, kernel_commit
// arms a bank swap at the next frame start; cfg_shift/cfg_abs shape the sum;
// out_valid/out_ready/out_data/out_sof/out_eol pixel output; sat_cnt clamps this frame.
module conv2d_stream_k #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 32,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int K      = 3,
    parameter int SHIFT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_W-1:0]           in_data,
    input  logic                       kernel_wr,
    input  logic [$clog2(K*K)-1:0]     kernel_addr,
    input  logic signed [COEF_W-1:0]   kernel_data,
    input  logic                       kernel_commit,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_abs,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIX_W-1:0]           out_data,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic [15:0]                sat_cnt
);
    localparam int N   = K * K;
    localparam int AW  = $clog2(N);
    localparam int PW  = COEF_W + PIX_W + 1;
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int CTR = N / 2;
    localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((1 << PIX_W) - 1);

    logic en, acc, swap, sat;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic act_q, act_d, pend_q, pend_d;
    logic signed [COEF_W-1:0] bank_q [2][N];
    logic signed [COEF_W-1:0] bank_d [2][N];
    logic [PIX_W-1:0] lb_q [K-1][IMG_W];
    logic [PIX_W-1:0] col [K];
    logic [PIX_W-1:0] win_q [N];
    logic [PIX_W-1:0] win_d [N];
    logic v1_q, v1_d, sof1_q, sof1_d, eol1_q, eol1_d, tag1_q, tag1_d;
    logic signed [PW-1:0] prod_q [N];
    logic signed [PW-1:0] prod_d [N];
    logic v2_q, v2_d, sof2_q, sof2_d, eol2_q, eol2_d;
    logic signed [ACC_W-1:0] sum_q, sum_d, sum_all, s_abs, s_rnd, s_sh;
    logic v3_q, v3_d, sof3_q, sof3_d, eol3_q, eol3_d;
    logic out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
    logic [PIX_W-1:0] out_data_q, out_data_d;
    logic [15:0] sat_q, sat_d;

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign sat_cnt   = sat_q;

    always_comb begin
        en   = out_ready || !out_valid_q;
        acc  = in_valid && en;
        swap = acc && x_q == '0 && y_q == '0 && pend_q;
        x_d  = x_q;
        y_d  = y_q;
        if (acc) begin
            x_d = (x_q == XW'(IMG_W - 1)) ? '0 : x_q + XW'(1);
            if (x_q == XW'(IMG_W - 1))
                y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
        end
        act_d  = swap ? !act_q : act_q;
        // a commit landing on the swap edge arms the following swap
        pend_d = swap ? kernel_commit : (pend_q || kernel_commit);
        bank_d = bank_q;
        // write addresses the pre-swap shadow even on the swap edge
        if (kernel_wr && kernel_addr < AW'(N))
            bank_d[!act_q][kernel_addr] = kernel_data;
        // column entering the window: oldest line at row 0, live pixel at row K-1
        for (int r = 0; r < K - 1; r++)
            col[r] = lb_q[K-2-r][x_q];
        col[K-1] = in_data;
        win_d = win_q;
        if (acc)
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win_d[r*K+c] = win_q[r*K+c+1];
                win_d[r*K+K-1] = col[r];
            end
        sum_all = '0;
        for (int i = 0; i < N; i++)
            sum_all = sum_all + ACC_W'(prod_q[i]);
        s_abs = (cfg_abs && sum_q < 0) ? -sum_q : sum_q;
        // half of 2^shift, zero when shift is zero
        s_rnd = (ACC_W'(1) << cfg_shift) >> 1;
        s_sh  = (s_abs + s_rnd) >>> cfg_shift;
        sat   = s_sh < 0 || s_sh > PMAX;
        {v1_d, sof1_d, eol1_d, tag1_d} = {v1_q, sof1_q, eol1_q, tag1_q};
        {v2_d, sof2_d, eol2_d} = {v2_q, sof2_q, eol2_q};
        {v3_d, sof3_d, eol3_d} = {v3_q, sof3_q, eol3_q};
        prod_d      = prod_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        sat_d       = sat_q;
        if (en) begin
            v1_d   = acc && x_q >= XW'(K - 1) && y_q >= YW'(K - 1);
            sof1_d = x_q == XW'(K - 1) && y_q == YW'(K - 1);
            eol1_d = x_q == XW'(IMG_W - 1);
            tag1_d = act_d;
            for (int i = 0; i < N; i++)
                prod_d[i] = PW'(bank_q[tag1_q][i]) * PW'($signed({1'b0, win_q[i]}));
            {v2_d, sof2_d, eol2_d} = {v1_q, sof1_q, eol1_q};
            sum_d = sum_all;
            {v3_d, sof3_d, eol3_d} = {v2_q, sof2_q, eol2_q};
            out_valid_d = v3_q;
            if (v3_q) begin
                out_data_d = (s_sh < 0) ? '0 : sat ? PMAX[PIX_W-1:0] : s_sh[PIX_W-1:0];
                out_sof_d  = sof3_q;
                out_eol_d  = eol3_q;
                sat_d = sof3_q ? 16'(sat) : (sat && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            act_q  <= 1'b0;
            pend_q <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < N; i++)
                    bank_q[b][i] <= (i == CTR) ? COEF_W'(1 << SHIFT) : '0;
            for (int i = 0; i < N; i++) begin
                win_q[i]  <= '0;
                prod_q[i] <= '0;
            end
            {v1_q, sof1_q, eol1_q, tag1_q} <= '0;
            {v2_q, sof2_q, eol2_q} <= '0;
            {v3_q, sof3_q, eol3_q} <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            sat_q       <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            bank_q <= bank_d;
            win_q  <= win_d;
            prod_q <= prod_d;
            {v1_q, sof1_q, eol1_q, tag1_q} <= {v1_d, sof1_d, eol1_d, tag1_d};
            {v2_q, sof2_q, eol2_q} <= {v2_d, sof2_d, eol2_d};
            {v3_q, sof3_q, eol3_q} <= {v3_d, sof3_d, eol3_d};
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            sat_q       <= sat_d;
        end
    end

    // line buffers hold don't-care data until refilled, so they carry no reset
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_q[0][x_q] <= in_data;
            for (int r = 1; r < K - 1; r++)
                lb_q[r][x_q] <= lb_q[r-1][x_q];
        end
    end
endmodule

// File: tb/tb_conv2d_stream_k.sv
// tb_conv2d_stream_k: directed checks of conv2d_stream_k on an 8x6 frame with a 3x3 kernel.
module tb_conv2d_stream_k;
    localparam int W = 8, H = 6, K = 3, N = 9;

    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready;
    logic [7:0] in_data = 0;
    logic kernel_wr = 0, kernel_commit = 0;
    logic [3:0] kernel_addr = 0;
    logic signed [15:0] kernel_data = 0;
    logic [4:0] cfg_shift = 5'd8;
    logic cfg_abs = 0;
    logic out_valid, out_ready = 1, out_sof, out_eol;
    logic [7:0] out_data;
    logic [15:0] sat_cnt;

    conv2d_stream_k #(.PIX_W(8), .COEF_W(16), .ACC_W(32), .IMG_W(W), .IMG_H(H), .K(K), .SHIFT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .kernel_wr(kernel_wr), .kernel_addr(kernel_addr), .kernel_data(kernel_data),
        .kernel_commit(kernel_commit), .cfg_shift(cfg_shift), .cfg_abs(cfg_abs),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int d; bit sof; bit eol; int sat;} obs_t;
    typedef struct {int ctr; bit ones; int sh; bit ab; int pix; int exp_d; int exp_sat;} vec_t;

    obs_t got[$], exp_q[$];
    int checks = 0, fails = 0, cyc = 0, first_ov = -1, acc22 = -1;
    int kern[N], kmod[N];
    bit bp = 0;
    vec_t tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, out_ready || !out_valid);
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) got.push_back('{int'(out_data), out_sof, out_eol, int'(sat_cnt)});
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? ~out_ready : 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    function automatic int pixv(input bit ramp, input int cval, input int x, input int y);
        return ramp ? x + 8 * y : cval;
    endfunction

    task automatic beat(input int p, input bit mark);
        bit a;
        int t;
        t = 0;
        in_valid = 1;
        in_data = 8'(p);
        do begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!a && t < 200);
        if (!a) chk("beat accept", a, 1);
        if (mark) acc22 = cyc;
        in_valid = 0;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < N; i++) begin
            kernel_wr = 1;
            kernel_addr = 4'(i);
            kernel_data = 16'(kern[i]);
            @(posedge clk);
            #1;
        end
        kernel_wr = 0;
        kernel_commit = 1;
        @(posedge clk);
        #1;
        kernel_commit = 0;
    endtask

    task automatic feed_frame(input bit ramp, input int cval, input bit load_mid, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int x, y;
            x = i % W;
            y = i / W;
            if (load_mid && i == 3 * W) load_kernel();
            beat(pixv(ramp, cval, x, y), x == 2 && y == 2);
        end
    endtask

    task automatic build_exp(input bit ramp, input int cval, input int sh, input bit ab);
        int s, satc;
        bit st;
        satc = 0;
        exp_q.delete();
        for (int y = 2; y < H; y++)
            for (int x = 2; x < W; x++) begin
                s = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        s += kmod[r*3+c] * pixv(ramp, cval, x - 2 + c, y - 2 + r);
                if (ab && s < 0) s = -s;
                if (sh > 0) s = (s + (1 << (sh - 1))) >>> sh;
                st = s < 0 || s > 255;
                s = s < 0 ? 0 : (s > 255 ? 255 : s);
                satc = (x == 2 && y == 2) ? int'(st) : (satc == 65535 ? satc : satc + int'(st));
                exp_q.push_back('{s, x == 2 && y == 2, x == W - 1, satc});
            end
    endtask

    task automatic wait_outputs(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cmp_frame(input string tag);
        wait_outputs(exp_q.size());
        chk({tag, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s data[%0d]", tag, i), got[i].d, exp_q[i].d);
            chk($sformatf("%s sof[%0d]", tag, i), got[i].sof, exp_q[i].sof);
            chk($sformatf("%s eol[%0d]", tag, i), got[i].eol, exp_q[i].eol);
            chk($sformatf("%s sat[%0d]", tag, i), got[i].sat, exp_q[i].sat);
        end
        got.delete();
    endtask

    task automatic set_identity_model();
        for (int i = 0; i < N; i++) kmod[i] = (i == 4) ? 256 : 0;
    endtask

    initial begin
        tbl = '{
            '{1,   1, 0, 0, 200, 255, 24},
            '{-1,  0, 0, 1, 7,   7,   0},
            '{-1,  0, 0, 0, 7,   0,   24},
            '{6,   0, 2, 0, 1,   2,   0},
            '{1,   1, 4, 0, 10,  6,   0},
            '{-3,  0, 1, 1, 5,   8,   0},
            '{3,   0, 1, 0, 1,   2,   0},
            '{-3,  0, 1, 0, 1,   0,   24},
            '{256, 0, 8, 0, 255, 255, 0},
            '{257, 0, 8, 0, 255, 255, 24}
        };

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_sof", out_sof, 0);
        chk("reset out_eol", out_eol, 0);
        chk("reset sat_cnt", sat_cnt, 0);
        rst = 0;

        set_identity_model();
        build_exp(1, 0, 8, 0);
        first_ov = -1;
        feed_frame(1, 0, 0, W * H);
        cmp_frame("ident");
        chk("latency", first_ov - acc22, 3);

        bp = 1;
        build_exp(1, 0, 8, 0);
        feed_frame(1, 0, 0, W * H);
        cmp_frame("backpressure");
        bp = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) kern[i] = 1;
        build_exp(1, 0, 8, 0);
        feed_frame(1, 0, 1, W * H);
        cmp_frame("swap f1");
        cfg_shift = 0;
        for (int i = 0; i < N; i++) kmod[i] = 1;
        build_exp(1, 0, 0, 0);
        feed_frame(1, 0, 0, W * H);
        cmp_frame("swap f2");

        feed_frame(1, 0, 0, 5 * W);
        repeat (6) @(posedge clk);
        #1;
        chk("pre-reset out_data", out_data, 255);
        chk("pre-reset sat_cnt", sat_cnt, 2);
        #2 rst = 1;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset out_data", out_data, 0);
        chk("async reset sat_cnt", sat_cnt, 0);
        @(posedge clk);
        #1;
        rst = 0;
        got.delete();
        cfg_shift = 8;
        set_identity_model();
        build_exp(1, 0, 8, 0);
        feed_frame(1, 0, 0, W * H);
        cmp_frame("restart");

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N; i++) kern[i] = tbl[v].ones ? 1 : (i == 4 ? tbl[v].ctr : 0);
            load_kernel();
            cfg_shift = 5'(tbl[v].sh);
            cfg_abs = tbl[v].ab;
            feed_frame(0, tbl[v].pix, 0, W * H);
            wait_outputs(24);
            chk($sformatf("vec%0d count", v), got.size(), 24);
            for (int i = 0; i < got.size(); i++)
                chk($sformatf("vec%0d data[%0d]", v, i), got[i].d, tbl[v].exp_d);
            if (got.size() > 0) begin
                chk($sformatf("vec%0d sof", v), got[0].sof, 1);
                chk($sformatf("vec%0d sat_cnt", v), got[got.size()-1].sat, tbl[v].exp_sat);
            end
            got.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
